// File: rtl/fifo_multi_push_n.sv
// Multi-push, single-pop FIFO: up to P lanes pushed per cycle into P rotating banks, one pop per cycle.
// Define FIFO_MULTI_PUSH_N_PARTIAL_EN to admit a partial push group; otherwise admission is all-or-nothing.
module fifo_multi_push_n #(
  parameter int W = 32,
  parameter int N = 16,
  parameter int P = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [P-1:0]             push_vec,
  input  logic [P*W-1:0]           push_data,
  output logic [P-1:0]             push_acc_vec,
  input  logic                     pop,
  output logic                     pop_valid_r,
  output logic [W-1:0]             pop_data_r,
  output logic                     empty_r,
  output logic [$clog2(N+1)-1:0]   free_r,
  output logic                     push_err_r,
  output logic                     pop_err_r
);

  localparam int D  = N / P;
  localparam int BW = $clog2(P);
  localparam int IW = $clog2(D);
  localparam int CW = $clog2(N + 1);

  typedef logic [IW:0] ptr_t;

  // Per-bank pointers carry a wrap bit above the entry index.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p[IW-1:0] == IW'(D - 1)) return {~p[IW], {IW{1'b0}}};
    return p + ptr_t'(1);
  endfunction

  logic [W-1:0]  mem [P][D];
  ptr_t          wr_ptr [P];
  ptr_t          rd_ptr [P];
  logic [BW-1:0] wr_bank;
  logic [BW-1:0] rd_bank;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_next;
  logic [BW:0]   acc_cnt;
  logic [BW-1:0] lane_bank [P];
  logic          pop_acc;

  // Admission looks only at the registered free count; a same-cycle pop gives no credit.
  always_comb begin
`ifdef FIFO_MULTI_PUSH_N_PARTIAL_EN
    int granted;
    granted = 0;
    push_acc_vec = '0;
    for (int i = 0; i < P; i++) begin
      if (push_vec[i] && (granted < int'(free_r))) begin
        push_acc_vec[i] = 1'b1;
        granted++;
      end
    end
`else
    push_acc_vec = '0;
    if ($countones(push_vec) <= int'(free_r)) push_acc_vec = push_vec;
`endif
  end

  assign acc_cnt  = (BW+1)'($countones(push_acc_vec));
  assign pop_acc  = pop && !empty_r;
  assign occ_next = occ + CW'(acc_cnt) - CW'(pop_acc);

  // Accepted lanes are compacted in lane order onto consecutive banks from wr_bank.
  always_comb begin
    logic [BW-1:0] rank;
    rank = '0;
    for (int i = 0; i < P; i++) begin
      lane_bank[i] = wr_bank + rank;
      if (push_acc_vec[i]) rank = rank + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < P; i++) begin
      if (push_acc_vec[i]) mem[lane_bank[i]][wr_ptr[lane_bank[i]][IW-1:0]] <= push_data[i*W +: W];
    end
    if (pop_acc) pop_data_r <= mem[rd_bank][rd_ptr[rd_bank][IW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank     <= '0;
      rd_bank     <= '0;
      for (int b = 0; b < P; b++) begin
        wr_ptr[b] <= '0;
        rd_ptr[b] <= '0;
      end
      occ         <= '0;
      empty_r     <= 1'b1;
      free_r      <= CW'(N);
      pop_valid_r <= 1'b0;
      push_err_r  <= 1'b0;
      pop_err_r   <= 1'b0;
    end else begin
      for (int i = 0; i < P; i++) begin
        if (push_acc_vec[i]) wr_ptr[lane_bank[i]] <= ptr_inc(wr_ptr[lane_bank[i]]);
      end
      wr_bank <= wr_bank + acc_cnt[BW-1:0];
      if (pop_acc) begin
        rd_ptr[rd_bank] <= ptr_inc(rd_ptr[rd_bank]);
        rd_bank         <= rd_bank + BW'(1);
      end
      occ         <= occ_next;
      free_r      <= CW'(N) - occ_next;
      empty_r     <= (occ_next == '0);
      pop_valid_r <= pop_acc;
      push_err_r  <= |(push_vec & ~push_acc_vec);
      pop_err_r   <= pop && empty_r;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) assert ((int'(occ) + int'(acc_cnt) - int'(pop_acc)) >= 0 &&
                      (int'(occ) + int'(acc_cnt) - int'(pop_acc)) <= N);
  end
`endif

endmodule

// File: tb/tb_fifo_multi_push_n.sv
// Directed bench for fifo_multi_push_n (W=32, N=16, P=4); honours FIFO_MULTI_PUSH_N_PARTIAL_EN.
module tb_fifo_multi_push_n;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   push_vec;
  logic [127:0] push_data;
  logic [3:0]   push_acc_vec;
  logic         pop;
  logic         pop_valid_r;
  logic [31:0]  pop_data_r;
  logic         empty_r;
  logic [4:0]   free_r;
  logic         push_err_r;
  logic         pop_err_r;

  int checks = 0;
  int errors = 0;

  fifo_multi_push_n #(.W(32), .N(16), .P(4)) dut (
    .clk(clk), .rst(rst), .push_vec(push_vec), .push_data(push_data),
    .push_acc_vec(push_acc_vec), .pop(pop), .pop_valid_r(pop_valid_r),
    .pop_data_r(pop_data_r), .empty_r(empty_r), .free_r(free_r),
    .push_err_r(push_err_r), .pop_err_r(pop_err_r)
  );

  always #5 clk = ~clk;

  // Lane i carries base+i; inputs settle 1 time unit before anything is sampled.
  task automatic applyStimulus(input logic [3:0] pv, input logic [31:0] base, input logic pp);
    push_vec = pv;
    for (int i = 0; i < 4; i++) push_data[i*32 +: 32] = base + 32'(i);
    pop = pp;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(4'b0000, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_empty", 32'(empty_r), 32'd1);
    checkOutput("reset_free", 32'(free_r), 32'd16);
    checkOutput("reset_pop_valid", 32'(pop_valid_r), 32'd0);
    checkOutput("reset_push_err", 32'(push_err_r), 32'd0);
    checkOutput("reset_pop_err", 32'(pop_err_r), 32'd0);

    // Pop on an empty FIFO
    applyStimulus(4'b0000, 32'h0, 1'b1);
    tick();
    checkOutput("empty_pop_err", 32'(pop_err_r), 32'd1);
    checkOutput("empty_pop_valid", 32'(pop_valid_r), 32'd0);
    checkOutput("empty_pop_free", 32'(free_r), 32'd16);
    applyStimulus(4'b0000, 32'h0, 1'b0);
    tick();
    checkOutput("pop_err_pulse", 32'(pop_err_r), 32'd0);

    // Sparse lane group 1011, then three pops
    applyStimulus(4'b1011, 32'hA0, 1'b0);
    checkOutput("sparse_acc", 32'(push_acc_vec), 32'hB);
    tick();
    checkOutput("sparse_free", 32'(free_r), 32'd13);
    checkOutput("sparse_empty", 32'(empty_r), 32'd0);
    applyStimulus(4'b0000, 32'h0, 1'b1);
    tick();
    checkOutput("sparse_pop0_valid", 32'(pop_valid_r), 32'd1);
    checkOutput("sparse_pop0", pop_data_r, 32'hA0);
    tick();
    checkOutput("sparse_pop1", pop_data_r, 32'hA1);
    tick();
    checkOutput("sparse_pop2", pop_data_r, 32'hA3);
    applyStimulus(4'b0000, 32'h0, 1'b0);
    tick();
    checkOutput("sparse_drained_valid", 32'(pop_valid_r), 32'd0);
    checkOutput("sparse_drained_empty", 32'(empty_r), 32'd1);
    checkOutput("sparse_drained_free", 32'(free_r), 32'd16);

    // Fill completely with four full-width groups
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b1111, 32'h100 + 32'(4 * c), 1'b0);
      checkOutput($sformatf("fill_acc_%0d", c), 32'(push_acc_vec), 32'hF);
      tick();
      checkOutput($sformatf("fill_free_%0d", c), 32'(free_r), 32'(12 - 4 * c));
    end
    applyStimulus(4'b0001, 32'h300, 1'b0);
    checkOutput("full_acc", 32'(push_acc_vec), 32'h0);
    tick();
    checkOutput("full_push_err", 32'(push_err_r), 32'd1);
    checkOutput("full_free", 32'(free_r), 32'd0);

    // Push and pop together while full: pop wins, push rejected
    applyStimulus(4'b0001, 32'h300, 1'b1);
    checkOutput("full_pp_acc", 32'(push_acc_vec), 32'h0);
    tick();
    checkOutput("full_pp_valid", 32'(pop_valid_r), 32'd1);
    checkOutput("full_pp_data", pop_data_r, 32'h100);
    checkOutput("full_pp_free", 32'(free_r), 32'd1);
    checkOutput("full_pp_push_err", 32'(push_err_r), 32'd1);
    applyStimulus(4'b0000, 32'h0, 1'b1);
    for (int i = 1; i < 16; i++) begin
      tick();
      checkOutput($sformatf("drain_data_%0d", i), pop_data_r, 32'h100 + 32'(i));
      if (i == 1) checkOutput("drain_push_err", 32'(push_err_r), 32'd0);
    end
    applyStimulus(4'b0000, 32'h0, 1'b0);
    tick();
    checkOutput("drain_empty", 32'(empty_r), 32'd1);
    checkOutput("drain_free", 32'(free_r), 32'd16);

    // Three pushes plus one pop per cycle, crossing bank and pointer wrap
    begin
      int next_pop;
      next_pop = 0;
      for (int c = 0; c < 6; c++) begin
        applyStimulus(4'b0111, 32'h200 + 32'(3 * c), 1'b1);
        checkOutput($sformatf("mix_acc_%0d", c), 32'(push_acc_vec), 32'h7);
        tick();
        checkOutput($sformatf("mix_free_%0d", c), 32'(free_r), 32'(13 - 2 * c));
        checkOutput($sformatf("mix_valid_%0d", c), 32'(pop_valid_r), (c > 0) ? 32'd1 : 32'd0);
        checkOutput($sformatf("mix_pop_err_%0d", c), 32'(pop_err_r), (c == 0) ? 32'd1 : 32'd0);
        if (c > 0) begin
          checkOutput($sformatf("mix_data_%0d", c), pop_data_r, 32'h200 + 32'(next_pop));
          next_pop++;
        end
      end
      applyStimulus(4'b0000, 32'h0, 1'b1);
      for (int i = 0; i < 13; i++) begin
        tick();
        checkOutput($sformatf("mix_drain_valid_%0d", i), 32'(pop_valid_r), 32'd1);
        checkOutput($sformatf("mix_drain_data_%0d", i), pop_data_r, 32'h200 + 32'(next_pop));
        next_pop++;
      end
      applyStimulus(4'b0000, 32'h0, 1'b0);
      tick();
      checkOutput("mix_popped_total", 32'(next_pop), 32'd18);
      checkOutput("mix_empty", 32'(empty_r), 32'd1);
      checkOutput("mix_free", 32'(free_r), 32'd16);
    end

    // Leave exactly two free entries, then request four lanes
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1111, 32'h400 + 32'(4 * c), 1'b0);
      tick();
    end
    applyStimulus(4'b0011, 32'h40C, 1'b0);
    tick();
    checkOutput("two_left_free", 32'(free_r), 32'd2);
    applyStimulus(4'b1111, 32'h500, 1'b0);
`ifdef FIFO_MULTI_PUSH_N_PARTIAL_EN
    checkOutput("partial_acc", 32'(push_acc_vec), 32'h3);
    tick();
    checkOutput("partial_free", 32'(free_r), 32'd0);
`else
    checkOutput("all_or_none_acc", 32'(push_acc_vec), 32'h0);
    tick();
    checkOutput("all_or_none_free", 32'(free_r), 32'd2);
`endif
    checkOutput("over_request_push_err", 32'(push_err_r), 32'd1);

    // Reset mid-operation discards contents
    applyStimulus(4'b0000, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset_empty", 32'(empty_r), 32'd1);
    checkOutput("midreset_free", 32'(free_r), 32'd16);
    checkOutput("midreset_push_err", 32'(push_err_r), 32'd0);
    applyStimulus(4'b0000, 32'h0, 1'b1);
    tick();
    checkOutput("midreset_pop_err", 32'(pop_err_r), 32'd1);
    checkOutput("midreset_pop_valid", 32'(pop_valid_r), 32'd0);
    applyStimulus(4'b0000, 32'h0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
